legv8_alu_sequencer: RTL and testbench
======================================

Name: legv8_alu_sequencer

Overview:
- Multi-cycle control sequencer for the LEGv8 datapath.
- Accepts one 32-bit instruction per valid/ready handshake and decodes it.
- Drives the ALU selection code (alu_enable), operand select, immediate, register addresses and memory/writeback strobes, stepping through DECODE/EXEC/MEM/WB states.
- It is the producer side of the ALU's 4-bit selection interface; the ALU consumes alu_enable.

Parameters:
- MEM_TIMEOUT, 15, max cycles waiting in MEM for mem_ack before aborting with err.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- instr_valid  in  1  instruction available.
- instr  in  32  instruction word, sampled when instr_valid && instr_ready.
- instr_ready  out  1  high only in IDLE.
- alu_enable  out  4  ALU selection code.
- alu_src_imm  out  1  1 = ALU B operand is imm; 0 = register Rm.
- imm  out  32  sign-extended immediate.
- rn  out  5  ALU A register address.
- rm  out  5  ALU B register address.
- rd  out  5  destination register address.
- mem_read  out  1  load request, held through MEM.
- mem_write  out  1  store request, held through MEM.
- mem_ack  in  1  memory completion.
- reg_write  out  1  one-cycle writeback strobe.
- branch  out  1  one-cycle PC-redirect strobe, CBZ/CBNZ.
- err  out  1  one-cycle strobe: illegal opcode or memory timeout.

Behaviour:
- Reset values:
  - State IDLE; instr_ready=1.
  - alu_enable=4'b0010; alu_src_imm=0; imm=0; rn=rm=rd=0.
  - All strobes 0.
  - A reset in any state, including MEM with a request held, returns to IDLE on the next edge with all strobes 0. No writeback occurs.
- States: IDLE, DECODE, EXEC, MEM, WB.
- IDLE:
  - On handshake, latch instr and go to DECODE.
  - instr_ready falls the following cycle.
- DECODE:
  - Register all datapath outputs. They stay stable until the next return to IDLE.
  - Unrecognised opcode: err=1 for this cycle, next state IDLE, no other strobe.
- Opcode decode (instr[31:21], or instr[31:24] for CB):

  | Instr | Opcode | alu_enable | alu_src_imm | rd / path |
  |---|---|---|---|---|
  | ADD | 10001011000 | 0010 | 0 | rd=instr[4:0] |
  | SUB | 11001011000 | 1010 | 0 | rd=instr[4:0] |
  | AND | 10001010000 | 0110 | 0 | rd=instr[4:0] |
  | ORR | 10101010000 | 0100 | 0 | rd=instr[4:0] |
  | LDUR | 11111000010 | 0010 | 1 | load path |
  | STUR | 11111000000 | 0010 | 1 | store path |
  | CBZ | 10110100 | 0111 | 1 | branch path |
  | CBNZ | 10110101 | 0001 | 1 | branch path |

- Register addresses:
  - R-format: rn=instr[9:5], rm=instr[20:16].
  - D-format: rn=instr[9:5], rd=instr[4:0] (Rt).
  - CB-format: rn=instr[4:0] (Rt); rm=0; rd=0.
- Immediates:
  - D-format: imm = sign-extend(instr[20:12]).
  - CB-format: imm = sign-extend(instr[23:5]) << 2, arithmetic on 32 bits; overflow bits discarded.
- EXEC (one cycle):
  - R-type: next WB.
  - LDUR/STUR: next MEM.
  - CBZ/CBNZ: branch=1 this cycle, next IDLE. The taken/not-taken decision belongs to the datapath via the ALU result.
- MEM:
  - mem_read (LDUR) or mem_write (STUR) is high every cycle in MEM.
  - On mem_ack: LDUR goes to WB; STUR goes to IDLE.
  - mem_ack in the same cycle MEM is entered counts.
  - If the wait counter reaches MEM_TIMEOUT without mem_ack: err=1, drop the request, go to IDLE.
  - mem_ack outside MEM is ignored.
- WB: reg_write=1 for exactly one cycle, next IDLE.
- Latency from handshake edge to return to IDLE:

  | Instruction | Cycles |
  |---|---|
  | R-type | 4 |
  | CB | 3 |
  | Illegal | 2 |
  | LDUR | 4 + ack wait |
  | STUR | 3 + ack wait |

- No instruction is accepted while busy. instr_valid held high is accepted only on re-entry to IDLE, with no duplicate acceptance.

Decomposition:
- Shared package legv8_pkg holds:
  - opcode constants;
  - ALU code constants (ALU_ADD=0010, ALU_SUB=1010, ALU_AND=0110, ALU_OR=0100, ALU_NOR=0101, ALU_NAND=1100, ALU_CBZ=0111, ALU_CBNZ=0001, ALU_MOV=1101);
  - state enum;
  - instruction format enum (R, D, CB, ILLEGAL).
- One combinational sub-module, legv8_opcode_decode: instr → format, alu code, imm, register fields, legal flag.
- The FSM, timeout counter and output registers live in the top module.

Test Plan:
- ADD: instr=0x8B020023 → DECODE: alu_enable=0010, alu_src_imm=0, rn=1, rm=2, rd=3 → reg_write pulse 3 cycles after handshake → instr_ready high the cycle after.
- SUB: instr=0xCB020023 → alu_enable=1010, rn=1, rm=2, rd=3, one reg_write, no mem strobes.
- LDUR: instr=0xF85F8045 → imm=0xFFFFFFF8, rn=2, rd=5, alu_src_imm=1; mem_ack after 3 MEM cycles → mem_read high exactly 3 cycles, then one reg_write.
- CBZ: instr=0xB4000064 → alu_enable=0111, rn=4, imm=0x0000000C, branch pulse in EXEC, no reg_write.
- Illegal/timeout: instr=0x00000000 → err pulse in DECODE, IDLE next cycle. Separately, STUR 0xF8000045 with mem_ack never asserted → err after MEM_TIMEOUT cycles, mem_write drops.
- Reset in MEM: LDUR in flight, reset asserted for 1 cycle → next cycle IDLE, mem_read=0, reg_write never pulses, alu_enable=0010.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared LEGv8 control definitions: opcodes, ALU selection codes, FSM states, decode record.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package legv8_pkg;

   // 11-bit opcodes, instr[31:21]
   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   // 8-bit CB opcodes, instr[31:24]
   localparam logic [7:0]  OP_CBZ  = 8'b10110100;
   localparam logic [7:0]  OP_CBNZ = 8'b10110101;

   // ALU selection codes consumed by the datapath ALU
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b1010;
   localparam logic [3:0] ALU_AND  = 4'b0110;
   localparam logic [3:0] ALU_OR   = 4'b0100;
   localparam logic [3:0] ALU_NOR  = 4'b0101;
   localparam logic [3:0] ALU_NAND = 4'b1100;
   localparam logic [3:0] ALU_CBZ  = 4'b0111;
   localparam logic [3:0] ALU_CBNZ = 4'b0001;
   localparam logic [3:0] ALU_MOV  = 4'b1101;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      FMT_R       = 2'd0,
      FMT_D       = 2'd1,
      FMT_CB      = 2'd2,
      FMT_ILLEGAL = 2'd3
   } fmt_e;

   // Everything the sequencer needs to remember about one instruction
   typedef struct packed {
      fmt_e        fmt;
      logic        legal;
      logic        is_load;
      logic [3:0]  alu;
      logic        src_imm;
      logic [31:0] imm;
      logic [4:0]  rn;
      logic [4:0]  rm;
      logic [4:0]  rd;
   } dec_t;

   // Idle/illegal record: ADD selection, no immediate, register 0 everywhere
   localparam dec_t DEC_RESET = '{fmt: FMT_ILLEGAL, legal: 1'b0, is_load: 1'b0,
                                  alu: ALU_ADD, src_imm: 1'b0, imm: 32'd0,
                                  rn: 5'd0, rm: 5'd0, rd: 5'd0};

endpackage

// File: rtl/legv8_alu_sequencer_if.sv
// Bundle of instruction handshake, ALU/register controls and memory strobes.
// Latency: none (wiring only).
// Backpressure: instr_ready from the sequencer gates instr_valid acceptance.
interface legv8_alu_sequencer_if;

   logic        instr_valid;
   logic [31:0] instr;
   logic        instr_ready;
   logic [3:0]  alu_enable;
   logic        alu_src_imm;
   logic [31:0] imm;
   logic [4:0]  rn;
   logic [4:0]  rm;
   logic [4:0]  rd;
   logic        mem_read;
   logic        mem_write;
   logic        mem_ack;
   logic        reg_write;
   logic        branch;
   logic        err;

   // Sequencer side
   modport master (
      input  instr_valid, instr, mem_ack,
      output instr_ready, alu_enable, alu_src_imm, imm, rn, rm, rd,
             mem_read, mem_write, reg_write, branch, err
   );

   // Fetch/datapath/memory side
   modport slave (
      output instr_valid, instr, mem_ack,
      input  instr_ready, alu_enable, alu_src_imm, imm, rn, rm, rd,
             mem_read, mem_write, reg_write, branch, err
   );

endinterface

// File: rtl/legv8_opcode_decode.sv
// Combinational LEGv8 decode: format, ALU code, immediate, register fields, legal flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows i_instr.
module legv8_opcode_decode
   import legv8_pkg::*;
(
   input  logic [31:0] i_instr,
   output dec_t        o_dec
);

   logic [10:0] w_op;
   logic [7:0]  w_cb_op;
   logic [31:0] w_d_imm;
   logic [31:0] w_cb_imm;

   assign w_op     = i_instr[31:21];
   assign w_cb_op  = i_instr[31:24];
   assign w_d_imm  = {{23{i_instr[20]}}, i_instr[20:12]};
   // Word offset to byte offset; top bits of the extended value fall off
   assign w_cb_imm = {{11{i_instr[23]}}, i_instr[23:5], 2'b00};

   // Classify the opcode, then fill in the fields that format carries
   always_comb begin
      o_dec = DEC_RESET;
      case (w_op)
         OP_ADD:  begin o_dec.fmt = FMT_R; o_dec.alu = ALU_ADD; end
         OP_SUB:  begin o_dec.fmt = FMT_R; o_dec.alu = ALU_SUB; end
         OP_AND:  begin o_dec.fmt = FMT_R; o_dec.alu = ALU_AND; end
         OP_ORR:  begin o_dec.fmt = FMT_R; o_dec.alu = ALU_OR;  end
         OP_LDUR: begin o_dec.fmt = FMT_D; o_dec.is_load = 1'b1; end
         OP_STUR: begin o_dec.fmt = FMT_D; end
         default: begin
            case (w_cb_op)
               OP_CBZ:  begin o_dec.fmt = FMT_CB; o_dec.alu = ALU_CBZ;  end
               OP_CBNZ: begin o_dec.fmt = FMT_CB; o_dec.alu = ALU_CBNZ; end
               default: ;
            endcase
         end
      endcase

      case (o_dec.fmt)
         FMT_R: begin
            o_dec.legal = 1'b1;
            o_dec.rn    = i_instr[9:5];
            o_dec.rm    = i_instr[20:16];
            o_dec.rd    = i_instr[4:0];
         end
         FMT_D: begin
            o_dec.legal   = 1'b1;
            o_dec.src_imm = 1'b1;
            o_dec.imm     = w_d_imm;
            o_dec.rn      = i_instr[9:5];
            o_dec.rd      = i_instr[4:0];
         end
         FMT_CB: begin
            // Rt is tested against zero, so it is the ALU A operand
            o_dec.legal   = 1'b1;
            o_dec.src_imm = 1'b1;
            o_dec.imm     = w_cb_imm;
            o_dec.rn      = i_instr[4:0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/legv8_alu_sequencer.sv
// Multi-cycle LEGv8 control sequencer: IDLE -> DECODE -> EXEC -> (MEM) -> (WB) -> IDLE.
// Latency: R 4, CB 3, illegal 2, LDUR 4+ack wait, STUR 3+ack wait cycles handshake to IDLE.
// Backpressure: instr_ready only in IDLE; memory stalls on mem_ack up to MEM_TIMEOUT cycles.
module legv8_alu_sequencer
   import legv8_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
)(
   input  logic                    clk,
   input  logic                    reset,
   legv8_alu_sequencer_if.master   io_bus
);

   localparam int            CW        = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

   localparam logic [2:0] S_IDLE   = ST_IDLE;
   localparam logic [2:0] S_DECODE = ST_DECODE;
   localparam logic [2:0] S_EXEC   = ST_EXEC;
   localparam logic [2:0] S_MEM    = ST_MEM;
   localparam logic [2:0] S_WB     = ST_WB;

   logic [2:0]    r_state;
   dec_t          r_dec;
   logic [CW-1:0] r_wait;
   dec_t          w_dec;
   logic          w_in_mem;
   logic          w_timeout;

   legv8_opcode_decode u_decode (
      .i_instr (io_bus.instr),
      .o_dec   (w_dec)
   );

   // State walk; the decoded record is captured at the handshake and held until the next one
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_dec   <= DEC_RESET;
         r_wait  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (io_bus.instr_valid) begin
                  r_dec   <= w_dec;
                  r_state <= S_DECODE;
               end
            end
            S_DECODE: r_state <= r_dec.legal ? S_EXEC : S_IDLE;
            S_EXEC: begin
               r_wait <= '0;
               case (r_dec.fmt)
                  FMT_R:   r_state <= S_WB;
                  FMT_D:   r_state <= S_MEM;
                  default: r_state <= S_IDLE;
               endcase
            end
            S_MEM: begin
               if (io_bus.mem_ack) begin
                  r_state <= r_dec.is_load ? S_WB : S_IDLE;
               end else if (r_wait == WAIT_LAST) begin
                  r_state <= S_IDLE;
               end else begin
                  r_wait <= r_wait + CW'(1);
               end
            end
            S_WB:    r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Last MEM cycle without an ack aborts the access
   assign w_in_mem  = (r_state == S_MEM);
   assign w_timeout = w_in_mem && !io_bus.mem_ack && (r_wait == WAIT_LAST);

   assign io_bus.instr_ready = (r_state == S_IDLE);
   assign io_bus.alu_enable  = r_dec.alu;
   assign io_bus.alu_src_imm = r_dec.src_imm;
   assign io_bus.imm         = r_dec.imm;
   assign io_bus.rn          = r_dec.rn;
   assign io_bus.rm          = r_dec.rm;
   assign io_bus.rd          = r_dec.rd;
   assign io_bus.mem_read    = w_in_mem && r_dec.is_load;
   assign io_bus.mem_write   = w_in_mem && !r_dec.is_load;
   assign io_bus.reg_write   = (r_state == S_WB);
   assign io_bus.branch      = (r_state == S_EXEC) && (r_dec.fmt == FMT_CB);
   assign io_bus.err         = ((r_state == S_DECODE) && !r_dec.legal) || w_timeout;

endmodule

// File: tb/tb_legv8_alu_sequencer.sv
// Self-checking bench for legv8_alu_sequencer: directed cases plus random instruction stream.
// Latency: reference timeline built per instruction from the cycle counts of each class.
// Backpressure: random instr_valid while busy and random mem_ack outside MEM must be ignored.
module tb_legv8_alu_sequencer;

   localparam int TO   = 15;
   localparam int K_ILL = 0;
   localparam int K_R   = 1;
   localparam int K_LD  = 2;
   localparam int K_ST  = 3;
   localparam int K_CB  = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks   = 0;
   int   failures = 0;
   logic [51:0] last_dp;

   legv8_alu_sequencer_if bus ();

   legv8_alu_sequencer #(.MEM_TIMEOUT(TO)) dut (
      .clk    (clk),
      .reset  (reset),
      .io_bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // {ready, mem_read, mem_write, reg_write, branch, err}
   function automatic logic [5:0] obs_strobes();
      return {bus.instr_ready, bus.mem_read, bus.mem_write, bus.reg_write, bus.branch, bus.err};
   endfunction

   function automatic logic [51:0] obs_dp();
      return {bus.alu_enable, bus.alu_src_imm, bus.imm, bus.rn, bus.rm, bus.rd};
   endfunction

   // Reference decode straight from the instruction table
   function automatic void model(input logic [31:0] ins, output int kind, output logic [51:0] dp);
      logic [3:0]  alu;
      logic        src;
      logic [31:0] imm;
      logic [4:0]  rn, rm, rd;
      int          v;
      alu = 4'b0010; src = 1'b0; imm = 32'd0; rn = 5'd0; rm = 5'd0; rd = 5'd0;
      kind = K_ILL;
      case (ins[31:21])
         11'b10001011000: begin kind = K_R;  alu = 4'b0010; end
         11'b11001011000: begin kind = K_R;  alu = 4'b1010; end
         11'b10001010000: begin kind = K_R;  alu = 4'b0110; end
         11'b10101010000: begin kind = K_R;  alu = 4'b0100; end
         11'b11111000010: begin kind = K_LD; alu = 4'b0010; end
         11'b11111000000: begin kind = K_ST; alu = 4'b0010; end
         default: ;
      endcase
      if (ins[31:24] == 8'b10110100) begin kind = K_CB; alu = 4'b0111; end
      if (ins[31:24] == 8'b10110101) begin kind = K_CB; alu = 4'b0001; end
      if (kind == K_R) begin
         rn = ins[9:5]; rm = ins[20:16]; rd = ins[4:0];
      end else if (kind == K_LD || kind == K_ST) begin
         src = 1'b1; rn = ins[9:5]; rd = ins[4:0];
         v = int'(ins[20:12]);
         if (v >= 256) v -= 512;
         imm = 32'(v);
      end else if (kind == K_CB) begin
         src = 1'b1; rn = ins[4:0];
         v = int'(ins[23:5]);
         if (v >= 262144) v -= 524288;
         imm = 32'(v * 4);
      end
      if (kind == K_ILL) begin
         alu = 4'b0010; src = 1'b0; imm = 32'd0; rn = 5'd0; rm = 5'd0; rd = 5'd0;
      end
      dp = {alu, src, imm, rn, rm, rd};
   endfunction

   // Busy cycles after the handshake; k = MEM cycle carrying the ack, 0 = never acked
   function automatic int busy_len(input int kind, input int k);
      case (kind)
         K_ILL:   return 1;
         K_R:     return 3;
         K_CB:    return 2;
         K_LD:    return (k > 0) ? 3 + k : 2 + TO;
         default: return (k > 0) ? 2 + k : 2 + TO;
      endcase
   endfunction

   // Expected strobes in busy cycle i (0 = first cycle after the handshake)
   function automatic logic [5:0] exp_strobe(input int kind, input int k, input int i);
      logic [5:0] e;
      int m;
      e = 6'b000000;
      case (kind)
         K_ILL: if (i == 0) e[0] = 1'b1;
         K_R:   if (i == 2) e[2] = 1'b1;
         K_CB:  if (i == 1) e[1] = 1'b1;
         default: begin
            m = (k > 0) ? k : TO;
            if (i >= 2 && i < 2 + m) begin
               if (kind == K_LD) e[4] = 1'b1;
               else              e[3] = 1'b1;
            end
            if (k == 0 && i == 1 + m) e[0] = 1'b1;
            if (kind == K_LD && k > 0 && i == 2 + m) e[2] = 1'b1;
         end
      endcase
      return e;
   endfunction

   // Entered at a negedge in IDLE; leaves at the negedge of the following IDLE cycle
   task automatic run_instr(input logic [31:0] ins, input int k);
      int          kind;
      int          n;
      logic [51:0] dp;
      logic        mem_kind;
      model(ins, kind, dp);
      n        = busy_len(kind, k);
      mem_kind = (kind == K_LD || kind == K_ST);
      check_val("hs_ready", 64'(bus.instr_ready), 64'(1'b1));
      bus.instr_valid = 1'b1;
      bus.instr       = ins;
      @(posedge clk); #1;
      for (int i = 0; i < n; i++) begin
         bus.instr_valid = 1'($urandom_range(0, 1));
         bus.instr       = $urandom;
         if (mem_kind && i >= 2) bus.mem_ack = (k > 0 && i == 1 + k);
         else                    bus.mem_ack = 1'($urandom_range(0, 1));
         @(negedge clk);
         check_val($sformatf("strobe_c%0d_k%0d", i, kind), 64'(obs_strobes()), 64'(exp_strobe(kind, k, i)));
         if (kind != K_ILL) check_val($sformatf("dp_c%0d", i), 64'(obs_dp()), 64'(dp));
         if (i == 0) last_dp = obs_dp();
         @(posedge clk); #1;
      end
      bus.instr_valid = 1'b0;
      bus.mem_ack     = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_val("back_idle", 64'(obs_strobes()), 64'(6'b100000));
   endtask

   function automatic logic [31:0] rand_instr(input int sel);
      logic [31:0] w;
      w = $urandom;
      case (sel)
         0: w[31:21] = 11'b10001011000;
         1: w[31:21] = 11'b11001011000;
         2: w[31:21] = 11'b10001010000;
         3: w[31:21] = 11'b10101010000;
         4: w[31:21] = 11'b11111000010;
         5: w[31:21] = 11'b11111000000;
         6: w[31:24] = 8'b10110100;
         7: w[31:24] = 8'b10110101;
         default: w[31] = 1'b0;
      endcase
      return w;
   endfunction

   initial begin
      bus.instr_valid = 1'b0;
      bus.instr       = 32'd0;
      bus.mem_ack     = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_val("rst_strobes", 64'(obs_strobes()), 64'(6'b100000));
      check_val("rst_dp", 64'(obs_dp()), 64'({4'b0010, 1'b0, 32'd0, 5'd0, 5'd0, 5'd0}));

      // Directed cases
      run_instr(32'h8B020023, 0);
      check_val("add_dp", 64'(last_dp), 64'({4'b0010, 1'b0, 32'd0, 5'd1, 5'd2, 5'd3}));
      run_instr(32'hCB020023, 0);
      check_val("sub_dp", 64'(last_dp), 64'({4'b1010, 1'b0, 32'd0, 5'd1, 5'd2, 5'd3}));
      run_instr(32'hF85F8045, 3);
      check_val("ldur_dp", 64'(last_dp), 64'({4'b0010, 1'b1, 32'hFFFFFFF8, 5'd2, 5'd0, 5'd5}));
      run_instr(32'hB4000064, 0);
      check_val("cbz_dp", 64'(last_dp), 64'({4'b0111, 1'b1, 32'h0000000C, 5'd4, 5'd0, 5'd0}));
      run_instr(32'h00000000, 0);
      run_instr(32'hF8000045, 0);
      run_instr(32'hF85F8045, 1);
      run_instr(32'hF8000045, TO);

      // Random stream
      for (int t = 0; t < 60; t++) begin
         run_instr(rand_instr($urandom_range(0, 8)), $urandom_range(0, TO));
      end

      // Reset while a load waits in MEM
      bus.instr_valid = 1'b1;
      bus.instr       = 32'hF85F8045;
      @(posedge clk); #1;
      bus.instr_valid = 1'b0;
      bus.mem_ack     = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      @(negedge clk);
      check_val("pre_rst_mem_read", 64'(bus.mem_read), 64'(1'b1));
      reset = 1'b1;
      @(posedge clk); #1;
      reset       = 1'b0;
      bus.mem_ack = 1'b1;
      @(negedge clk);
      check_val("mem_rst_strobes", 64'(obs_strobes()), 64'(6'b100000));
      check_val("mem_rst_alu", 64'(bus.alu_enable), 64'(4'b0010));
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         bus.mem_ack = 1'($urandom_range(0, 1));
         @(negedge clk);
         check_val($sformatf("post_rst_c%0d", i), 64'(obs_strobes()), 64'(6'b100000));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
